load_store_unit: RTL

//   Initiator side of the data-memory interface for the RV32I core. Accepts one load/store

---
 rtl/load_store_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I data-memory initiator: alignment check, byte strobes, fixed-latency load return
module load_store_unit #(
    parameter int ADDR_W  = 12,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic              o_resp_err,
    output logic [31:0]       o_resp_rdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic              o_mem_ld,
    output logic              o_mem_str,
    output logic [3:0]        o_mem_wstrb,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic               r_we;
    logic [2:0]         r_funct3;
    logic [1:0]         r_off;
    logic [2:0]         r_cnt;
    logic [3:0]         r_wstrb;
    logic [ADDR_W-1:0]  r_mem_address;
    logic [31:0]        r_mem_wdata;
    logic               r_resp_err;
    logic [31:0]        r_resp_rdata;

    logic               w_accept;
    logic               w_bad_f3;
    logic               w_misal;
    logic               w_err;
    logic [3:0]         w_wstrb;
    logic [31:0]        w_wdata;
    logic [31:0]        w_shift;
    logic [31:0]        w_load_data;
    logic               w_unused_addr;

    // Upper address bits wrap modulo the memory size and are deliberately dropped.
    assign w_unused_addr = ^i_req_addr[31:ADDR_W+2];

    // Request legality: funct3 decode per direction plus natural alignment.
    always_comb begin
        w_bad_f3 = 1'b0;
        if (i_req_we)
            w_bad_f3 = (i_req_funct3 > 3'd2);
        else
            w_bad_f3 = (i_req_funct3 == 3'd3) || (i_req_funct3[2:1] == 2'b11);
        w_misal  = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0])
                || ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
        w_err    = w_bad_f3 | w_misal;
        w_accept = (r_state == S_IDLE) && i_req_valid;
    end

    // Store lane steering: replicate data so every enabled lane sees its byte.
    always_comb begin
        w_wstrb = 4'b1111;
        w_wdata = i_req_wdata;
        case (i_req_funct3[1:0])
            2'b00: begin
                w_wstrb = 4'b0001 << i_req_addr[1:0];
                w_wdata = {4{i_req_wdata[7:0]}};
            end
            2'b01: begin
                w_wstrb = i_req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_req_wdata[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = i_req_wdata;
            end
        endcase
    end

    // Load extraction: shift the addressed lane down, then sign/zero extend.
    always_comb begin
        w_shift     = i_mem_rdata >> {r_off, 3'b000};
        w_load_data = i_mem_rdata;
        case (r_funct3)
            3'd0:    w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'd4:    w_load_data = {24'd0, w_shift[7:0]};
            3'd1:    w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'd5:    w_load_data = {16'd0, w_shift[15:0]};
            default: w_load_data = i_mem_rdata;
        endcase
    end

    // State register; reset parks in IDLE so strobes fall immediately.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_next       = r_state;
        o_req_ready  = 1'b0;
        o_resp_valid = 1'b0;
        o_mem_ld     = 1'b0;
        o_mem_str    = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid)
                    w_next = w_err ? S_RESP : S_ACCESS;
            end
            S_ACCESS: begin
                o_mem_ld  = ~r_we;
                o_mem_str = r_we;
                w_next    = r_we ? S_RESP : S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 3'd1)
                    w_next = S_RESP;
            end
            S_RESP: begin
                o_resp_valid = 1'b1;
                w_next       = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        o_busy      = ~o_req_ready;
        o_mem_wstrb = o_mem_str ? r_wstrb : 4'b0000;
    end

    // Request capture, latency counter and response data registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we          <= 1'b0;
            r_funct3      <= 3'd0;
            r_off         <= 2'd0;
            r_cnt         <= 3'd0;
            r_wstrb       <= 4'd0;
            r_mem_address <= '0;
            r_mem_wdata   <= 32'd0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we         <= i_req_we;
                        r_funct3     <= i_req_funct3;
                        r_off        <= i_req_addr[1:0];
                        r_resp_err   <= w_err;
                        r_resp_rdata <= 32'd0;
                        if (!w_err) begin
                            r_mem_address <= i_req_addr[ADDR_W+1:2];
                            if (i_req_we) begin
                                r_wstrb     <= w_wstrb;
                                r_mem_wdata <= w_wdata;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we)
                        r_cnt <= LAT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1)
                        r_resp_rdata <= w_load_data;
                end
                default: ;
            endcase
        end
    end

    assign o_mem_address = r_mem_address;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_resp_err    = r_resp_err;
    assign o_resp_rdata  = r_resp_rdata;

endmodule
